// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into 32-bit words, buffers them in a small FIFO,
// and hands them one at a time to a handshaked instruction-memory write port.
module instr_encoder #(
  parameter int ADDR_W     = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [4:0]        opcode,
  input  logic [3:0]        ra,
  input  logic [3:0]        rb,
  input  logic [3:0]        rc,
  input  logic [31:0]       imm,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              mem_write,
  input  logic              mem_ack,
  output logic [ADDR_W:0]   count,
  output logic              range_err,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t state, state_next;

  logic [31:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   occupancy;
  logic             fifo_full, fifo_empty;
  logic             accept, needs_imm, imm_ok, push, pop;
  logic [31:0]      word;

  assign fifo_full  = (occupancy == DEPTH);
  assign fifo_empty = (occupancy == '0);
  assign in_ready   = !fifo_full && !clear;
  assign accept     = in_valid && in_ready;
  assign needs_imm  = (fmt == 2'd1) || (fmt == 2'd2);
  // The constant fits in 19 signed bits only if bits 31..18 are all copies of the sign.
  assign imm_ok     = (imm[31:18] == {14{imm[18]}});
  assign push       = accept && (!needs_imm || imm_ok);
  assign pop        = (state == WRITE) && mem_ack;

  always_comb begin
    word        = '0;
    word[31:27] = opcode;
    word[26:23] = ra;
    case (fmt)
      2'd0: begin
        word[22:19] = rb;
        word[18:15] = rc;
      end
      2'd1, 2'd2: begin
        word[22:19] = rb;
        word[18:0]  = imm[18:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= word;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + (PTR_W+1)'(1);
        2'b01:   occupancy <= occupancy - (PTR_W+1)'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (clear) range_err <= 1'b0;
    else if (accept && needs_imm && !imm_ok) range_err <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty) state_next = WRITE;
      WRITE:   if (mem_ack)     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_write = (state == WRITE);
    busy      = !fifo_empty || (state == WRITE);
  end

  // base_load is honoured only in IDLE and lands before the head is latched, so the next write uses it.
  always_ff @(posedge clock) begin
    if (clear) begin
      mem_addr <= '0;
      mem_data <= '0;
      count    <= '0;
    end else if (state == IDLE) begin
      if (base_load) begin
        mem_addr <= base_addr;
        count    <= '0;
      end
      if (!fifo_empty) mem_data <= fifo_mem[rd_ptr];
    end else if (mem_ack) begin
      mem_addr <= mem_addr + ADDR_W'(1);
      if (!count[ADDR_W]) count <= count + (ADDR_W+1)'(1);
    end
  end

endmodule
